// File: rtl/bram2_pkg.sv
// bram2_pkg: shared constants and elaboration helpers for the flow-controlled
// true-dual-port block RAM (bram2_flowctl) and its response-port sub-module.
//   BYTE_W            : bits per byte lane
//   MIN/MAX_READ_LAT  : legal range of the RAM read latency
//   clog2()           : ceiling log2, usable in constant expressions
//   read_latency_ok() : legality check for READ_LATENCY
//   data_width_ok()   : legality check for DATA_WIDTH (whole bytes only)
//   be_width()        : number of byte enables for a given data width
package bram2_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned MIN_READ_LAT     = 1;
  localparam int unsigned MAX_READ_LAT     = 2;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned BE_WIDTH         = DEF_DATA_WIDTH / BYTE_W;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat >= MIN_READ_LAT) && (lat <= MAX_READ_LAT);
  endfunction

  function automatic bit data_width_ok(input int unsigned dw);
    return (dw != 0) && ((dw % BYTE_W) == 0);
  endfunction

  function automatic int unsigned be_width(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/bram2_flowctl_rsp_port.sv
// bram2_rsp_port: per-port read-response path of bram2_flowctl.
// Tracks reads through the RAM latency, stores returned words in a small
// FIFO and manages credits so that the FIFO can never overflow.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   rd_req_i      : read request (EN & !WE) from the port
//   deq_i         : consumer pops the FIFO head (ignored when empty)
//   rd_data_i     : RAM data, valid READ_LATENCY cycles after an accept
//   rdy_o         : a read can be accepted this cycle
//   valid_o       : data_o holds a valid response
//   data_o        : FIFO head
module bram2_rsp_port
  import bram2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rd_req_i,
  input  logic                  deq_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rdy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned CW = clog2(RSP_DEPTH + 1);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RSP_DEPTH);

  logic [READ_LATENCY-1:0] lat_q, lat_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           occ_q, occ_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   fifo_q [RSP_DEPTH];

  logic accept;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credits count in-flight reads plus stored responses, so accepting only
  // below RSP_DEPTH guarantees a free FIFO slot for every landing word.
  assign rdy_o   = (cnt_q < CNT_MAX);
  assign valid_o = (occ_q != '0);
  assign data_o  = fifo_q[rd_ptr_q];
  assign accept  = rd_req_i & rdy_o;
  assign push    = lat_q[READ_LATENCY-1];
  assign pop     = deq_i & valid_o;

  always_comb begin
    lat_d    = lat_q << 1;
    lat_d[0] = accept;
    cnt_d    = cnt_q + CW'(accept) - CW'(pop);
    occ_d    = occ_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_q    <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= rd_data_i;
      end
    end
  end

endmodule

// File: rtl/bram2_flowctl.sv
// bram2_flowctl: true-dual-port block RAM with byte enables, a read latency
// of 1 or 2 cycles and a credit-managed response FIFO per port.
//   CLK, RST_N          : clock (rising edge), asynchronous active-low reset
//   ENx, WEx            : request strobe, write (1) / read (0)
//   BEx, ADDRx, DIx     : byte enables (writes), address, write data
//   RDYx                : a read can be accepted (writes are always accepted)
//   DOx, VALIDx, DEQx   : response FIFO head, head valid, pop
// Same-address collisions: a read sees the old word; on double writes port B
// wins every lane both ports enable. Out-of-range writes are dropped and
// out-of-range reads return zero.
module bram2_flowctl
  import bram2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMSIZE      = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ENA,
  input  logic                    WEA,
  input  logic [DATA_WIDTH/8-1:0] BEA,
  input  logic [ADDR_WIDTH-1:0]   ADDRA,
  input  logic [DATA_WIDTH-1:0]   DIA,
  output logic                    RDYA,
  output logic [DATA_WIDTH-1:0]   DOA,
  output logic                    VALIDA,
  input  logic                    DEQA,
  input  logic                    ENB,
  input  logic                    WEB,
  input  logic [DATA_WIDTH/8-1:0] BEB,
  input  logic [ADDR_WIDTH-1:0]   ADDRB,
  input  logic [DATA_WIDTH-1:0]   DIB,
  output logic                    RDYB,
  output logic [DATA_WIDTH-1:0]   DOB,
  output logic                    VALIDB,
  input  logic                    DEQB
);

  localparam int unsigned BEW = be_width(DATA_WIDTH);
  localparam int unsigned MW  = (MEMSIZE > 1) ? clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEMSIZE);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("bram2_flowctl: READ_LATENCY must be 1 or 2");
  end
  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("bram2_flowctl: DATA_WIDTH must be a multiple of 8");
  end
  if (RSP_DEPTH < 1) begin : g_bad_depth
    $error("bram2_flowctl: RSP_DEPTH must be at least 1");
  end
  if (longint'(MEMSIZE) > (64'd1 << ADDR_WIDTH)) begin : g_bad_memsize
    $error("bram2_flowctl: MEMSIZE exceeds the address space");
  end

  logic [DATA_WIDTH-1:0] mem_q [MEMSIZE];
  logic [DATA_WIDTH-1:0] ram_a_q, ram_b_q;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;

  logic in_range_a, in_range_b;
  logic [MW-1:0] idx_a, idx_b;
  logic rd_req_a, rd_req_b;
  logic rd_fire_a, rd_fire_b;
  logic wr_a, wr_b;

  assign in_range_a = ({1'b0, ADDRA} < MEM_LIMIT);
  assign in_range_b = ({1'b0, ADDRB} < MEM_LIMIT);
  assign idx_a      = ADDRA[MW-1:0];
  assign idx_b      = ADDRB[MW-1:0];
  assign rd_req_a   = ENA & ~WEA;
  assign rd_req_b   = ENB & ~WEB;
  assign rd_fire_a  = rd_req_a & RDYA;
  assign rd_fire_b  = rd_req_b & RDYB;
  assign wr_a       = ENA & WEA & in_range_a;
  assign wr_b       = ENB & WEB & in_range_b;

  // Reads sample the array before this edge's writes land (old-data on
  // collision). Port B's lane writes follow port A's so B wins overlaps.
  always_ff @(posedge CLK) begin
    if (rd_fire_a) begin
      ram_a_q <= in_range_a ? mem_q[idx_a] : '0;
    end
    if (rd_fire_b) begin
      ram_b_q <= in_range_b ? mem_q[idx_b] : '0;
    end
    if (wr_a) begin
      for (int unsigned i = 0; i < BEW; i++) begin
        if (BEA[i]) begin
          mem_q[idx_a][i*BYTE_W +: BYTE_W] <= DIA[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (wr_b) begin
      for (int unsigned i = 0; i < BEW; i++) begin
        if (BEB[i]) begin
          mem_q[idx_b][i*BYTE_W +: BYTE_W] <= DIB[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_a_q, out_b_q;
    always_ff @(posedge CLK) begin
      out_a_q <= ram_a_q;
      out_b_q <= ram_b_q;
    end
    assign rd_data_a = out_a_q;
    assign rd_data_b = out_b_q;
  end else begin : g_no_out_reg
    assign rd_data_a = ram_a_q;
    assign rd_data_b = ram_b_q;
  end

  bram2_rsp_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .RSP_DEPTH   (RSP_DEPTH)
  ) u_rsp_a (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .rd_req_i (rd_req_a),
    .deq_i    (DEQA),
    .rd_data_i(rd_data_a),
    .rdy_o    (RDYA),
    .valid_o  (VALIDA),
    .data_o   (DOA)
  );

  bram2_rsp_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .RSP_DEPTH   (RSP_DEPTH)
  ) u_rsp_b (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .rd_req_i (rd_req_b),
    .deq_i    (DEQB),
    .rd_data_i(rd_data_b),
    .rdy_o    (RDYB),
    .valid_o  (VALIDB),
    .data_o   (DOB)
  );

endmodule

// File: tb/tb_bram2_flowctl.sv
// Bench for bram2_flowctl: dut1 uses READ_LATENCY=1/RSP_DEPTH=2 over a full
// 1024-word array, dut2 uses READ_LATENCY=2/RSP_DEPTH=3 with MEMSIZE=48 so
// out-of-range addresses are reachable. Index [d][s]: d = dut, s = port A/B.
module tb_bram2_flowctl;

  localparam int RLAT  [2] = '{1, 2};
  localparam int DEPTH [2] = '{2, 3};
  localparam int MSZ   [2] = '{1024, 48};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en    [2][2];
  logic        we    [2][2];
  logic        deq   [2][2];
  logic        rdy   [2][2];
  logic        valid [2][2];
  logic [3:0]  be    [2][2];
  logic [9:0]  addr  [2][2];
  logic [31:0] di    [2][2];
  logic [31:0] dout  [2][2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory image plus per-port ordered response queue
  // (entries live from read accept until pop, i.e. they are the credits).
  logic [31:0] mm [2][1024];
  logic [31:0] qd [4][8];
  int          qc [4][8];
  int          qh [4];
  int          qn [4];
  int          cyc;

  bram2_flowctl #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .MEMSIZE(1024), .READ_LATENCY(1), .RSP_DEPTH(2)
  ) dut1 (
    .CLK(clk), .RST_N(rst_n),
    .ENA(en[0][0]), .WEA(we[0][0]), .BEA(be[0][0]), .ADDRA(addr[0][0]), .DIA(di[0][0]),
    .RDYA(rdy[0][0]), .DOA(dout[0][0]), .VALIDA(valid[0][0]), .DEQA(deq[0][0]),
    .ENB(en[0][1]), .WEB(we[0][1]), .BEB(be[0][1]), .ADDRB(addr[0][1]), .DIB(di[0][1]),
    .RDYB(rdy[0][1]), .DOB(dout[0][1]), .VALIDB(valid[0][1]), .DEQB(deq[0][1])
  );

  bram2_flowctl #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .MEMSIZE(48), .READ_LATENCY(2), .RSP_DEPTH(3)
  ) dut2 (
    .CLK(clk), .RST_N(rst_n),
    .ENA(en[1][0]), .WEA(we[1][0]), .BEA(be[1][0]), .ADDRA(addr[1][0]), .DIA(di[1][0]),
    .RDYA(rdy[1][0]), .DOA(dout[1][0]), .VALIDA(valid[1][0]), .DEQA(deq[1][0]),
    .ENB(en[1][1]), .WEB(we[1][1]), .BEB(be[1][1]), .ADDRB(addr[1][1]), .DIB(di[1][1]),
    .RDYB(rdy[1][1]), .DOB(dout[1][1]), .VALIDB(valid[1][1]), .DEQB(deq[1][1])
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        en[d][s] = 1'b0; we[d][s] = 1'b0; deq[d][s] = 1'b0;
        be[d][s] = 4'h0; addr[d][s] = 10'd0; di[d][s] = 32'h0;
      end
    end
  endtask

  task automatic wr(input int d, input int s, input int a, input logic [31:0] v, input logic [3:0] b);
    en[d][s] = 1'b1; we[d][s] = 1'b1; addr[d][s] = 10'(a); di[d][s] = v; be[d][s] = b;
  endtask

  task automatic rd(input int d, input int s, input int a);
    en[d][s] = 1'b1; we[d][s] = 1'b0; addr[d][s] = 10'(a); deq[d][s] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        n_cmp++;
        if (valid[d][s] !== 1'b0) begin
          n_bad++; $display("FAIL reset_valid[%0d][%0d]: got %b expected 0", d, s, valid[d][s]);
        end
        n_cmp++;
        if (rdy[d][s] !== 1'b1) begin
          n_bad++; $display("FAIL reset_rdy[%0d][%0d]: got %b expected 1", d, s, rdy[d][s]);
        end
        n_cmp++;
        if (dout[d][s] !== 32'h0) begin
          n_bad++; $display("FAIL reset_do[%0d][%0d]: got %h expected 0", d, s, dout[d][s]);
        end
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    idle();
    wr(0, 0, 5, 32'hDEADBEEF, 4'hF);
    step();
    rd(0, 0, 5);
    n_cmp++;
    if (rdy[0][0] !== 1'b1) begin
      n_bad++; $display("FAIL wr_rd_rdy: got %b expected 1", rdy[0][0]);
    end
    step();
    en[0][0] = 1'b0;
    n_cmp++;
    if (valid[0][0] !== 1'b0) begin
      n_bad++; $display("FAIL wr_rd_no_bypass: valid got %b expected 0", valid[0][0]);
    end
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wr_rd_data: valid=%b do=%h expected 1/deadbeef", valid[0][0], dout[0][0]);
    end
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b0) begin
      n_bad++; $display("FAIL wr_rd_popped: valid got %b expected 0", valid[0][0]);
    end
    idle();
  endtask

  task automatic test_byte_enables();
    idle();
    wr(0, 0, 9, 32'h11223344, 4'hF);
    wr(0, 1, 10, 32'h11223344, 4'hF);
    step();
    wr(0, 0, 9, 32'hAABBCCDD, 4'b0101);
    wr(0, 1, 10, 32'hAABBCCDD, 4'b1010);
    step();
    rd(0, 0, 9);
    rd(0, 1, 10);
    step();
    en[0][0] = 1'b0; en[0][1] = 1'b0;
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL be_lo: valid=%b do=%h expected 1/11bb33dd", valid[0][0], dout[0][0]);
    end
    n_cmp++;
    if (valid[0][1] !== 1'b1 || dout[0][1] !== 32'hAA22CC44) begin
      n_bad++; $display("FAIL be_hi: valid=%b do=%h expected 1/aa22cc44", valid[0][1], dout[0][1]);
    end
    step();
    idle();
  endtask

  task automatic test_backpressure();
    int acc;
    idle();
    for (int i = 0; i < 6; i++) begin
      wr(1, 1, i, 32'h100 + 32'(i), 4'hF);
      step();
    end
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      en[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 10'(i); deq[1][1] = 1'b0;
      n_cmp++;
      if (rdy[1][1] !== ((i < 3) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL bp_rdy_issue%0d: got %b expected %b", i, rdy[1][1], (i < 3));
      end
      if (rdy[1][1] === 1'b1) acc++;
      step();
    end
    en[1][1] = 1'b0;
    n_cmp++;
    if (acc != 3) begin
      n_bad++; $display("FAIL bp_accepted: got %0d expected 3", acc);
    end
    n_cmp++;
    if (rdy[1][1] !== 1'b0) begin
      n_bad++; $display("FAIL bp_rdy_full: got %b expected 0", rdy[1][1]);
    end
    deq[1][1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (valid[1][1] !== 1'b1 || dout[1][1] !== 32'h100 + 32'(k)) begin
        n_bad++; $display("FAIL bp_pop%0d: valid=%b do=%h expected 1/%h", k, valid[1][1], dout[1][1], 32'h100 + 32'(k));
      end
      step();
      if (k == 0) begin
        n_cmp++;
        if (rdy[1][1] !== 1'b1) begin
          n_bad++; $display("FAIL bp_rdy_return: got %b expected 1", rdy[1][1]);
        end
      end
    end
    deq[1][1] = 1'b0;
    n_cmp++;
    if (valid[1][1] !== 1'b0) begin
      n_bad++; $display("FAIL bp_drained: valid got %b expected 0", valid[1][1]);
    end
    idle();
  endtask

  task automatic test_collision();
    idle();
    wr(0, 0, 7, 32'h1, 4'hF);
    step();
    rd(0, 0, 7);
    wr(0, 1, 7, 32'h2, 4'hF);
    step();
    en[0][0] = 1'b0; en[0][1] = 1'b0;
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 32'h1) begin
      n_bad++; $display("FAIL coll_old_data: valid=%b do=%h expected 1/00000001", valid[0][0], dout[0][0]);
    end
    step();
    idle();
    wr(0, 0, 8, 32'h3, 4'hF);
    wr(0, 1, 8, 32'h4, 4'hF);
    step();
    idle();
    rd(0, 0, 8);
    step();
    en[0][0] = 1'b0;
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 32'h4) begin
      n_bad++; $display("FAIL coll_b_wins: valid=%b do=%h expected 1/00000004", valid[0][0], dout[0][0]);
    end
    step();
    idle();
    wr(0, 0, 9, 32'h55555555, 4'hF);
    wr(0, 1, 9, 32'h66666666, 4'b0011);
    step();
    idle();
    rd(0, 0, 7);
    rd(0, 1, 9);
    step();
    en[0][0] = 1'b0; en[0][1] = 1'b0;
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 32'h2) begin
      n_bad++; $display("FAIL coll_write_landed: valid=%b do=%h expected 1/00000002", valid[0][0], dout[0][0]);
    end
    n_cmp++;
    if (valid[0][1] !== 1'b1 || dout[0][1] !== 32'h55556666) begin
      n_bad++; $display("FAIL coll_lane_merge: valid=%b do=%h expected 1/55556666", valid[0][1], dout[0][1]);
    end
    step();
    idle();
  endtask

  task automatic test_reset_midflight();
    idle();
    en[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 10'd5;
    step();
    addr[0][0] = 10'd8;
    step();
    en[0][0] = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid[0][0] !== 1'b0 || rdy[0][0] !== 1'b1) begin
      n_bad++; $display("FAIL mid_async: valid=%b rdy=%b expected 0/1", valid[0][0], rdy[0][0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (valid[0][0] !== 1'b0 || rdy[0][0] !== 1'b1) begin
        n_bad++; $display("FAIL mid_after%0d: valid=%b rdy=%b expected 0/1", k, valid[0][0], rdy[0][0]);
      end
    end
    rd(0, 0, 5);
    step();
    en[0][0] = 1'b0;
    step();
    n_cmp++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL mid_mem_kept: valid=%b do=%h expected 1/deadbeef", valid[0][0], dout[0][0]);
    end
    step();
    idle();
  endtask

  // One clock of the scoreboard: checks outputs against the model, then
  // applies the currently driven stimulus to the model and advances a cycle.
  task automatic run_cycle();
    logic exp_rdy   [2][2];
    logic exp_valid [2][2];
    logic [31:0] rdat;
    int p, a, t;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        p = d * 2 + s;
        exp_rdy[d][s]   = (qn[p] < DEPTH[d]);
        exp_valid[d][s] = (qn[p] > 0) && (cyc >= qc[p][qh[p]] + RLAT[d] + 1);
        n_cmp++;
        if (rdy[d][s] !== exp_rdy[d][s]) begin
          n_bad++; $display("FAIL soak_rdy[%0d][%0d] cyc %0d: got %b expected %b", d, s, cyc, rdy[d][s], exp_rdy[d][s]);
        end
        n_cmp++;
        if (valid[d][s] !== exp_valid[d][s]) begin
          n_bad++; $display("FAIL soak_valid[%0d][%0d] cyc %0d: got %b expected %b", d, s, cyc, valid[d][s], exp_valid[d][s]);
        end
        if (exp_valid[d][s]) begin
          n_cmp++;
          if (dout[d][s] !== qd[p][qh[p]]) begin
            n_bad++; $display("FAIL soak_data[%0d][%0d] cyc %0d: got %h expected %h", d, s, cyc, dout[d][s], qd[p][qh[p]]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        p = d * 2 + s;
        a = int'(addr[d][s]);
        if (deq[d][s] && exp_valid[d][s]) begin
          qh[p] = (qh[p] + 1) % 8;
          qn[p] = qn[p] - 1;
        end
        if (en[d][s] && !we[d][s] && exp_rdy[d][s]) begin
          rdat = (a < MSZ[d]) ? mm[d][a] : 32'h0;
          t = (qh[p] + qn[p]) % 8;
          qd[p][t] = rdat;
          qc[p][t] = cyc;
          qn[p] = qn[p] + 1;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        a = int'(addr[d][s]);
        if (en[d][s] && we[d][s] && a < MSZ[d]) begin
          for (int l = 0; l < 4; l++) begin
            if (be[d][s][l]) mm[d][a][l*8 +: 8] = di[d][s][l*8 +: 8];
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_soak();
    int pct;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      qh[p] = 0; qn[p] = 0;
    end
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      wr(0, 0, i, $urandom, 4'hF);
      wr(0, 1, 15 - i, $urandom, 4'hF);
      wr(1, 0, 40 + i, $urandom, 4'hF);
      wr(1, 1, 55 - i, $urandom, 4'hF);
      run_cycle();
    end
    for (int k = 0; k < 3000; k++) begin
      pct = (((k / 250) % 3) == 0) ? 90 : ((((k / 250) % 3) == 1) ? 40 : 5);
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 2; s++) begin
          en[d][s]   = ($urandom_range(0, 3) != 0);
          we[d][s]   = ($urandom_range(0, 2) == 0);
          be[d][s]   = 4'($urandom);
          addr[d][s] = (d == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(40, 55));
          di[d][s]   = $urandom;
          deq[d][s]  = ($urandom_range(0, 99) < pct);
        end
      end
      run_cycle();
    end
    idle();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) deq[d][s] = 1'b1;
    end
    for (int k = 0; k < 12; k++) run_cycle();
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (qn[p] != 0) begin
        n_bad++; $display("FAIL soak_drain[%0d]: %0d responses outstanding, expected 0", p, qn[p]);
      end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_backpressure();
    test_collision();
    test_reset_midflight();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram2_flowctl.md
Name: bram2_flowctl

Overview:
- Parametrised true-dual-port block RAM with per-port request/response flow control.
- Successor to the stall-style dual-port BRAM: adds byte enables, read latency of 1 or 2, and a credit-managed response FIFO per port, so consumers may backpressure indefinitely without losing read data.
- Sits between Bluespec-generated logic and on-chip memory, replacing the raw DEQ-stall wrapper.

Parameters:
- ADDR_WIDTH, 10, address bits per port.
- DATA_WIDTH, 32, data bits. Must be a multiple of 8.
- MEMSIZE, 1024, number of words. Must be <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, RAM read latency: 1 = registered address only, 2 = output register also. Other values are illegal; elaboration fails.
- RSP_DEPTH, 2, per-port response FIFO depth. Must be >= READ_LATENCY+1 for full throughput, and >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ENA  in  1  port A request strobe.
- WEA  in  1  port A write (1) / read (0).
- BEA  in  DATA_WIDTH/8  port A byte enables (writes only).
- ADDRA  in  ADDR_WIDTH  port A address.
- DIA  in  DATA_WIDTH  port A write data.
- RDYA  out  1  port A can accept a read.
- DOA  out  DATA_WIDTH  port A response FIFO head.
- VALIDA  out  1  DOA holds a valid response.
- DEQA  in  1  pop port A response.
- ENB, WEB, BEB, ADDRB, DIB, RDYB, DOB, VALIDB, DEQB: same as port A, for port B.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Credit counters = 0, FIFOs empty, latency pipeline valid bits = 0.
  - VALIDx = 0, RDYx = 1, DOx = 0.
  - Memory contents are not reset.
- Reset mid-operation: all in-flight reads are discarded. No response emerges after release.
- Write: ENx & WEx is accepted every cycle regardless of RDYx.
  - Byte lane i is written only if BEx[i].
  - No response is generated.
- Read: ENx & !WEx is accepted only when RDYx=1. A read attempted while RDYx=0 is ignored and never issued.
- Read latency, for a read accepted in cycle t:
  - RAM data is valid in cycle t+READ_LATENCY.
  - It is written into the FIFO at the end of that cycle.
  - VALIDx rises in cycle t+READ_LATENCY+1.
  - There is no combinational bypass.
- Credits, per port:
  - cnt = in-flight reads + FIFO occupancy.
  - Read accept increments cnt; DEQx while VALIDx decrements it; both in the same cycle leave it unchanged.
  - RDYx = (cnt < RSP_DEPTH). The FIFO therefore can never overflow.
  - cnt width is clog2(RSP_DEPTH+1).
- DEQx while VALIDx=0 is ignored; the pointers and counter are unchanged.
- FIFO pointers wrap modulo RSP_DEPTH.
- Responses within a port return strictly in request order.
- Data held in the FIFO is unaffected by later writes (a snapshot at read time).
- Mixed-port collisions, same address in the same cycle:
  - Read on one port, write on the other: the read returns OLD data.
  - Both ports write: port B wins on every lane both enable. Other lanes take whichever port enabled them.
- ADDRx >= MEMSIZE: the write is dropped; the read returns 0 and still consumes and returns a credit.
- The ports are fully independent apart from sharing the memory array.

Decomposition:
- Package bram2_pkg:
  - localparam checks for legal READ_LATENCY and DATA_WIDTH%8.
  - Function clog2.
  - Constant BE_WIDTH = DATA_WIDTH/8.
- Sub-module bram2_rsp_port, instantiated twice:
  - Latency valid shift register, credit counter, response FIFO, RDY/VALID generation.
- The top level holds the inferred memory array, byte-lane write logic, collision resolution and the optional output register.

Test Plan:
- Reset and write/read, READ_LATENCY=1, RSP_DEPTH=2:
  - After reset, VALIDA=0 and RDYA=1.
  - Write A addr 5 data 0xDEADBEEF BE=4'hF, then read A addr 5 with DEQA=1 held.
  - VALIDA rises 2 cycles after read accept with DOA=0xDEADBEEF.
- Byte enables:
  - Write 0x11223344, then write 0xAABBCCDD with BE=4'b0101, then read.
  - Required response 0x11BB33DD.
- Backpressure, READ_LATENCY=2, RSP_DEPTH=3:
  - Issue reads to addrs 0..5 every cycle with DEQB=0.
  - Exactly 3 accepted, then RDYB=0.
  - Assert DEQB for 3 cycles: data for addrs 0,1,2 in order. RDYB returns high the cycle after the first pop.
- Collision:
  - Same cycle, A reads addr 7 (old 0x1) while B writes addr 7 with 0x2: DOA=0x1.
  - Next, both ports write addr 8 (A 0x3, B 0x4), then read addr 8: 0x4.
- Reset mid-flight:
  - Two reads in flight, assert RST_N=0 for 1 cycle.
  - VALIDA stays 0 for 5 cycles after release, and RDYA=1.
- Full-throughput soak:
  - Random reads and writes on both ports with random DEQ, checked against a scoreboard model.
  - No lost, duplicated or reordered responses.
  - RDYx never low while cnt < RSP_DEPTH.
